// File: rtl/djs130_dev_pkg.sv
// Shared definitions for DJS130 I/O bus devices.
//   KZ_*    : bit indices of the control-strobe bus i_dev_KZ
//   ZT_*    : bit positions of the {Busy, Done} status pair
//   DEV_*   : device codes presented on o_dev_DMs
//   tto_state_e : transmit framing state of the teletype-output device
package djs130_dev_pkg;

    localparam int KZ_DOA  = 0;
    localparam int KZ_S    = 6;
    localparam int KZ_C    = 7;

    localparam int ZT_BUSY = 1;
    localparam int ZT_DONE = 0;

    localparam logic [5:0] DEV_TTI = 6'o10;
    localparam logic [5:0] DEV_TTO = 6'o11;

    typedef enum logic [1:0] {
        TTO_IDLE,
        TTO_START,
        TTO_DATA,
        TTO_STOP
    } tto_state_e;

endpackage

// File: rtl/djs130_tto_uart_baud_tick.sv
// Bit-period timer for the teletype-output UART.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clr        : synchronous restart of the bit period (counter to 0)
//   en         : count while a frame is on the line
//   tick       : one-cycle pulse on the last cycle of every DIV-cycle period
// DIV must be at least 2.
module djs130_baud_tick #(
    parameter int unsigned DIV = 208
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] baud_cnt;

    assign tick = en && (baud_cnt == LAST);

    // Reloading to 0 on the tick keeps every bit exactly DIV cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt <= '0;
        end else if (clr) begin
            baud_cnt <= '0;
        end else if (en) begin
            baud_cnt <= tick ? '0 : baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/djs130_tto_uart.sv
// DJS130 teletype-output device: single-buffer Busy/Done I/O device that
// sends each character as an 8N1 frame on a UART TX line.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   i_dev_KZ    : control strobes (DOA load buffer, S start, C clear)
//   i_dev_SR    : CPU output data, low byte loaded on DOA
//   i_dev_ZZ0   : I/O reset pulse, same effect as C
//   o_dev_DMs   : device code
//   o_dev_ZT    : status {Busy, Done}
//   o_dev_ZDQQ  : interrupt request, follows Done
//   o_uart_tx   : serial line, idle high
module djs130_tto_uart
    import djs130_dev_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 24_000_000,
    parameter int unsigned BAUD     = 115200,
    parameter logic [5:0]  DEV_CODE = DEV_TTO
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [8:0]  i_dev_KZ,
    input  logic [15:0] i_dev_SR,
    input  logic        i_dev_ZZ0,
    output logic [5:0]  o_dev_DMs,
    output logic [1:0]  o_dev_ZT,
    output logic        o_dev_ZDQQ,
    output logic        o_uart_tx
);

    localparam int unsigned DIV = (CLK_HZ + BAUD / 2) / BAUD;

    tto_state_e state, state_n;
    logic [7:0] data_buf;
    logic [7:0] shreg, shreg_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic       busy, busy_n;
    logic       done, done_n;
    logic       tx_q, tx_n;

    logic       doa, start, clear;
    logic       go;
    logic       tick;

    // Strobe bits and data-bus bits this device does not decode.
    logic       unused_ok;
    assign unused_ok = &{1'b0, i_dev_KZ[8], i_dev_KZ[5:1], i_dev_SR[15:8]};

    assign doa   = i_dev_KZ[KZ_DOA];
    assign start = i_dev_KZ[KZ_S];
    assign clear = i_dev_KZ[KZ_C] | i_dev_ZZ0;
    assign go    = start && !busy;

    djs130_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear | go),
        .en    (state != TTO_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TTO_IDLE;
            data_buf <= '0;
            shreg    <= '0;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            busy     <= busy_n;
            done     <= done_n;
            tx_q     <= tx_n;
            if (doa) begin
                data_buf <= i_dev_SR[7:0];
            end
        end
    end

    // tx_n is the line level for the next cycle, so each bit appears on the
    // line from the cycle after the tick that closes the previous bit.
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        busy_n    = busy;
        done_n    = done;
        tx_n      = tx_q;

        if (clear) begin
            state_n = TTO_IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b0;
            tx_n    = 1'b1;
        end else if (go) begin
            // Same-cycle DOA bypasses the buffer so the new byte is sent.
            shreg_n = doa ? i_dev_SR[7:0] : data_buf;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            state_n = TTO_START;
            tx_n    = 1'b0;
        end else if (tick) begin
            case (state)
                TTO_START: begin
                    state_n   = TTO_DATA;
                    bit_cnt_n = '0;
                    tx_n      = shreg[0];
                    shreg_n   = {1'b0, shreg[7:1]};
                end
                TTO_DATA: begin
                    if (bit_cnt == 3'd7) begin
                        state_n = TTO_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = shreg[0];
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end
                TTO_STOP: begin
                    state_n = TTO_IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    tx_n    = 1'b1;
                end
                default: begin
                    state_n = TTO_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_dev_ZT          = '0;
        o_dev_ZT[ZT_BUSY] = busy;
        o_dev_ZT[ZT_DONE] = done;
    end

    assign o_dev_DMs  = DEV_CODE;
    assign o_dev_ZDQQ = done;
    assign o_uart_tx  = tx_q;

endmodule

// File: tb/tb_djs130_tto_uart.sv
// Directed bench for djs130_tto_uart: a DIV=4 instance for protocol and
// framing cases, and a default-parameter instance for the 115200/24 MHz rate.
module tb_djs130_tto_uart;
    import djs130_dev_pkg::*;

    localparam int unsigned D = 4;
    localparam int unsigned NREC = 4300;

    localparam logic [8:0] K_DOA = 9'b1 << KZ_DOA;
    localparam logic [8:0] K_S   = 9'b1 << KZ_S;
    localparam logic [8:0] K_C   = 9'b1 << KZ_C;

    logic        clk;
    logic        rst_n;
    logic [8:0]  kz;
    logic [15:0] sr;
    logic        zz0;

    logic [5:0]  dms_a, dms_b;
    logic [1:0]  zt_a, zt_b;
    logic        irq_a, irq_b;
    logic        tx_a, tx_b;

    int n_chk = 0;
    int n_err = 0;

    logic rec [0:NREC];
    int   done_cyc;
    int   low_run;
    bit   restarted;

    djs130_tto_uart #(
        .CLK_HZ (1000),
        .BAUD   (250)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_dev_KZ   (kz),
        .i_dev_SR   (sr),
        .i_dev_ZZ0  (zz0),
        .o_dev_DMs  (dms_a),
        .o_dev_ZT   (zt_a),
        .o_dev_ZDQQ (irq_a),
        .o_uart_tx  (tx_a)
    );

    djs130_tto_uart dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_dev_KZ   (kz),
        .i_dev_SR   (sr),
        .i_dev_ZZ0  (zz0),
        .o_dev_DMs  (dms_b),
        .o_dev_ZT   (zt_b),
        .o_dev_ZDQQ (irq_b),
        .o_uart_tx  (tx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the strobes over one active edge; returns in the following cycle.
    task automatic pulse(input logic [8:0] k, input logic [15:0] s, input logic z);
        kz  = k;
        sr  = s;
        zz0 = z;
        step(1);
        kz  = '0;
        zz0 = 1'b0;
    endtask

    function automatic logic fbit(input logic [7:0] d, input int unsigned b);
        if (b == 0) return 1'b0;
        if (b >= 9) return 1'b1;
        return d[b-1];
    endfunction

    // Called in frame cycle `first` (cycle 1 = first cycle after the S edge).
    task automatic frame_check(input string tag, input logic [7:0] d, input int unsigned first);
        for (int unsigned i = first; i <= 10 * D; i++) begin
            chk({tag, "_tx"}, tx_a, fbit(d, (i - 1) / D));
            chk({tag, "_busy"}, zt_a, 2'b10);
            step(1);
        end
        chk({tag, "_done"}, zt_a, 2'b01);
        chk({tag, "_irq"}, irq_a, 1'b1);
        chk({tag, "_idle"}, tx_a, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        kz    = '0;
        sr    = '0;
        zz0   = 1'b0;
        step(3);

        // Reset state
        chk("rst_tx_a", tx_a, 1'b1);
        chk("rst_zt_a", zt_a, 2'b00);
        chk("rst_irq_a", irq_a, 1'b0);
        chk("rst_tx_b", tx_b, 1'b1);
        chk("rst_zt_b", zt_b, 2'b00);
        chk("dms_a", dms_a, 6'o11);
        chk("dms_b", dms_b, 6'o11);
        rst_n = 1'b1;
        step(2);

        // 1: basic frame of 'A'
        pulse(K_DOA, 16'h0041, 1'b0);
        chk("t1_doa_no_start", zt_a, 2'b00);
        pulse(K_S, 16'h0000, 1'b0);
        frame_check("t1", 8'h41, 1);

        // 2: DOA and S together bypass the old buffer contents
        pulse(K_DOA, 16'h0000, 1'b0);
        pulse(K_DOA | K_S, 16'hFF55, 1'b0);
        frame_check("t2", 8'h55, 1);

        // 3: S while busy ignored; DOA while busy loads only the buffer
        pulse(K_DOA, 16'h003C, 1'b0);
        pulse(K_S, 16'h0000, 1'b0);
        step(9);
        pulse(K_S | K_DOA, 16'h00A5, 1'b0);
        frame_check("t3", 8'h3C, 11);
        for (int unsigned i = 0; i < 10 * D; i++) begin
            chk("t3_after_tx", tx_a, 1'b1);
            chk("t3_after_zt", zt_a, 2'b01);
            step(1);
        end
        pulse(K_S, 16'h0000, 1'b0);
        frame_check("t3_buf", 8'hA5, 1);

        // 4: C mid-frame, then resend preserved buffer
        pulse(K_DOA, 16'h0092, 1'b0);
        pulse(K_S, 16'h0000, 1'b0);
        step(12);
        chk("t4_pre_tx", tx_a, 1'b0);
        pulse(K_C, 16'h0000, 1'b0);
        chk("t4_c_tx", tx_a, 1'b1);
        chk("t4_c_zt", zt_a, 2'b00);
        chk("t4_c_irq", irq_a, 1'b0);
        for (int unsigned i = 0; i < 2 * D; i++) begin
            chk("t4_hold_tx", tx_a, 1'b1);
            chk("t4_hold_zt", zt_a, 2'b00);
            step(1);
        end
        pulse(K_S, 16'h0000, 1'b0);
        frame_check("t4_resend", 8'h92, 1);

        // 5a: ZZ0 on the frame-end cycle wins over done
        pulse(K_S, 16'h0000, 1'b0);
        step(39);
        chk("t5_last_busy", zt_a, 2'b10);
        pulse(9'h000, 16'h0000, 1'b1);
        chk("t5_zz0_zt", zt_a, 2'b00);
        chk("t5_zz0_irq", irq_a, 1'b0);
        chk("t5_zz0_tx", tx_a, 1'b1);
        step(2);
        chk("t5_zz0_hold", zt_a, 2'b00);

        // 5b: asynchronous reset mid-frame
        pulse(K_S, 16'h0000, 1'b0);
        step(5);
        chk("t5_pre_rst_tx", tx_a, 1'b0);
        chk("t5_pre_rst_zt", zt_a, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx_a, 1'b1);
        chk("t5_rst_zt", zt_a, 2'b00);
        chk("t5_rst_irq", irq_a, 1'b0);
        chk("t5_rst_tx_b", tx_b, 1'b1);
        step(2);
        rst_n = 1'b1;
        step(1);
        pulse(K_S, 16'h0000, 1'b0);
        frame_check("t5_rst_buf", 8'h00, 1);

        // 6: default rate, back-to-back frames
        pulse(K_C, 16'h0000, 1'b0);
        chk("t6_clr_zt", zt_b, 2'b00);
        pulse(K_DOA | K_S, 16'h0001, 1'b0);
        done_cyc  = 0;
        restarted = 1'b0;
        for (int i = 1; i <= NREC; i++) begin
            rec[i] = tx_b;
            if (!restarted && zt_b == 2'b01) begin
                done_cyc  = i;
                restarted = 1'b1;
                kz        = K_S;
            end
            step(1);
            kz = '0;
        end
        chk("t6_frame_len", done_cyc, 2081);
        low_run = 0;
        for (int i = 1; i <= NREC; i++) begin
            if (rec[i] !== 1'b0) break;
            low_run++;
        end
        chk("t6_start_len", low_run, 208);
        chk("t6_gap_cycle", rec[2081], 1'b1);
        chk("t6_restart", rec[2082], 1'b0);
        for (int b = 0; b < 10; b++) begin
            chk("t6_f1_bit", rec[1 + b * 208 + 104], fbit(8'h01, b));
            chk("t6_f2_bit", rec[2082 + b * 208 + 104], fbit(8'h01, b));
        end
        chk("t6_end_zt", zt_b, 2'b01);
        chk("t6_end_irq", irq_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/djs130_tto_uart.md
# djs130_tto_uart

Teletype-output device for the DJS130 I/O bus that sends characters over an asynchronous serial line. It is the transmit counterpart of the teletype-input device, which accepts host bytes. It attaches to the CPU device bus (KZ control strobes, SR output data, ZT status, ZDQQ interrupt request) and drives one 8N1 UART TX pin to the host terminal. It implements the classic single-buffer Busy/Done protocol, so existing TTO driver code runs unchanged.

## Interface
- CLK_HZ, 24_000_000, system clock frequency.
- BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD cycles per bit, which is 208 at the defaults; DIV ≥ 2 is required.
- DEV_CODE, 6'o11, device code driven on o_dev_DMs.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- i_dev_KZ  in  9  control strobes, each a one-cycle pulse: [0] DOA, load buffer; [6] S, start; [7] C, clear; all other bits ignored.
- i_dev_SR  in  16  CPU output data; [7:0] is sampled on DOA and [15:8] is ignored.
- i_dev_ZZ0  in  1  I/O reset pulse (IORST); same effect as C.
- o_dev_DMs  out  6  constant DEV_CODE.
- o_dev_ZT  out  2  status {Busy, Done}: [1] = Busy, [0] = Done.
- o_dev_ZDQQ  out  1  interrupt request; equals Done.
- o_uart_tx  out  1  serial line, idle high.

## Operation
- State registers:
  - buf[7:0]: holding buffer.
  - shreg[7:0]: shift register.
  - busy, done.
  - FSM {IDLE, START, DATA, STOP}.
  - bit_cnt[2:0].
  - baud_cnt: $clog2(DIV) bits.
- Reset values: buf = 0, shreg = 0, busy = 0, done = 0, FSM = IDLE, o_uart_tx = 1, o_dev_ZT = 2'b00, o_dev_ZDQQ = 0.
- DOA: buf ← SR[7:0] in any state. A DOA during a transmission does not disturb the frame in flight.
- S while not busy:
  - shreg ← buf, or SR[7:0] if DOA is asserted in the same cycle.
  - busy ← 1, done ← 0, FSM → START.
- S while busy: ignored; busy, done and the frame are unchanged.
- Frame format: start bit (0), then 8 data bits LSB first, then one stop bit (1). Each bit lasts exactly DIV cycles.
- Frame end: on the last cycle of the stop bit, busy ← 0, done ← 1, FSM → IDLE.
- C or ZZ0, in any state:
  - FSM → IDLE, o_uart_tx ← 1 immediately, busy ← 0, done ← 0, baud_cnt ← 0.
  - buf is preserved.
  - C or ZZ0 has priority over an S or a frame end in the same cycle.
- The interrupt request o_dev_ZDQQ follows Done. Masking is the CPU's job.

## Timing
- S sampled at edge t:
  - o_uart_tx = 0 from cycle t+1.
  - Data bit k (k = 0..7) occupies cycles t+1+(k+1)·DIV through t+(k+2)·DIV.
  - Stop bit occupies cycles t+1+9·DIV through t+10·DIV.
  - busy = 1 in cycles t+1 through t+10·DIV.
  - done = 1 and busy = 0 from cycle t+1+10·DIV.
- Total frame length is 10·DIV cycles. o_uart_tx is registered, so there are no glitches.
- Back-to-back: an S issued on the same cycle that done rises starts the next start bit immediately, with no idle gap beyond the one cycle of done.
- Status outputs are registered and change one cycle after the causing strobe.
- Baud counter: counts 0..DIV-1, reloads to 0 at each bit boundary, and wraps with no drift across the frame.
- Reset mid-frame: the line returns high asynchronously and all state is at reset values.

## Structure
- Package djs130_dev_pkg holds:
  - KZ bit indices: KZ_DOA = 0, KZ_S = 6, KZ_C = 7.
  - ZT bit positions: ZT_BUSY = 1, ZT_DONE = 0.
  - Device-code constants: DEV_TTI = 6'o10, DEV_TTO = 6'o11.
  - The FSM state enum.
- One sub-module, djs130_baud_tick:
  - Parameterised by DIV; inputs clk, rst_n, clr, en.
  - Emits a one-cycle tick at the end of every DIV-cycle bit period.
- Top level: FSM, shift register, buffer and status logic.

## Test plan
1. Basic frame (DIV = 4, from CLK_HZ = 1000 and BAUD = 250): DOA with SR = 16'h0041, then S → line reads 0,1,0,0,0,0,0,1,0,1 at 4 cycles per bit; ZT = 2'b10 for 40 cycles, then 2'b01; ZDQQ = 1.
2. DOA and S in the same cycle with SR = 16'hFF55, after an earlier buffer value of 8'h00 → transmits 8'h55 (bits 1,0,1,0,1,0,1,0), not 8'h00.
3. S at cycle 10 of a frame → ignored: the frame ends at exactly 10·DIV cycles and exactly one frame appears on the line; a DOA during the frame loads buf without corrupting the line.
4. C at cycle 13 of a frame → o_uart_tx = 1 the next cycle; ZT = 2'b00; ZDQQ = 0; a following S sends the full preserved buffer.
5. ZZ0 in the same cycle as the frame-end cycle → ZT = 2'b00 and done is not set; async rst_n mid-frame → all outputs at reset values before the next edge.
6. Default parameters: check DIV = 208 and a frame of 2080 cycles; back-to-back S on the cycle done rises gives no gap and a continuous 20-bit pattern.
